timer_ctrl_regs: RTL and testbench

//  Bus-side register front end that programs and observes the peripheral timer counter.

---
 rtl/timer_pkg.sv | 36 +++
 rtl/timer_ctrl_regs_if.sv | 17 +
 rtl/timer_evt_detect.sv | 30 +++
 rtl/timer_ctrl_regs.sv | 145 ++++++++++++++
 tb/tb_timer_ctrl_regs.sv | 334 +++++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/timer_pkg.sv
// Shared definitions for the timer register front end: register offsets,
// CTRL bit positions, the CTRL register layout and a byte-enable merge helper.
package timer_pkg;

  localparam logic [7:0] TMR_CTRL_OFF   = 8'h00;
  localparam logic [7:0] TMR_LOAD_OFF   = 8'h04;
  localparam logic [7:0] TMR_VALUE_OFF  = 8'h08;
  localparam logic [7:0] TMR_STATUS_OFF = 8'h0C;
  localparam logic [7:0] TMR_IRQCNT_OFF = 8'h10;

  localparam int CTRL_EN_BIT   = 0;
  localparam int CTRL_MODE_BIT = 1;
  localparam int CTRL_IE_BIT   = 2;

  typedef struct packed {
    logic ie;
    logic mode;
    logic en;
  } ctrl_t;

  function automatic logic [31:0] apply_be(input logic [31:0] cur,
                                           input logic [31:0] wdata,
                                           input logic [3:0]  be);
    logic [31:0] res;
    res = cur;
    for (int i = 0; i < 4; i++) begin
      if (be[i]) begin
        res[8*i +: 8] = wdata[8*i +: 8];
      end else begin
        res[8*i +: 8] = cur[8*i +: 8];
      end
    end
    return res;
  endfunction

endpackage

// File: rtl/timer_ctrl_regs_if.sv
// Core data bus (req/gnt/rvalid) between the core and the timer register block.
interface timer_ctrl_regs_if #(
  parameter int AW = 8
) ();
  logic          req;
  logic          we;
  logic [AW-1:0] addr;
  logic [3:0]    be;
  logic [31:0]   wdata;
  logic          gnt;
  logic          rvalid;
  logic [31:0]   rdata;
  logic          err;

  modport master (output req, we, addr, be, wdata, input gnt, rvalid, rdata, err);
  modport slave  (input req, we, addr, be, wdata, output gnt, rvalid, rdata, err);
endinterface

// File: rtl/timer_evt_detect.sv
// Rising-edge detector feeding a sticky pending flag; a new edge beats a
// same-cycle clear so no interrupt is ever lost.
module timer_evt_detect (
  input  logic clk,
  input  logic rstn,
  input  logic evt_in,
  input  logic clr,
  output logic flag,
  output logic set_pulse
);

  logic prev_r;
  logic flag_r;
  logic set_s;

  assign set_s     = evt_in & ~prev_r;
  assign set_pulse = set_s;
  assign flag      = flag_r;

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      prev_r <= 1'b0;
      flag_r <= 1'b0;
    end else begin
      prev_r <= evt_in;
      flag_r <= set_s | (flag_r & ~clr);
    end
  end

endmodule

// File: rtl/timer_ctrl_regs.sv
// Bus register front end for the peripheral timer counter.
// Optional IRQCNT register at 0x10 is built when TIMER_IRQ_COUNT_EN is defined.
module timer_ctrl_regs
  import timer_pkg::*;
#(
  parameter int          AW       = 8,
  parameter logic [31:0] LOAD_RST = 32'hFFFF_FFFF
) (
  input  logic                   clk,
  input  logic                   rstn,
  timer_ctrl_regs_if.slave       bus,
  output logic                   timer_enable,
  output logic                   timer_mode,
  output logic [31:0]            timer_load_count,
  input  logic [31:0]            timer_current_value,
  input  logic                   timer_irq_in,
  output logic                   irq_o
);

  ctrl_t          ctrl_r;
  logic [31:0]    load_r;
  logic           rvalid_r;
  logic [31:0]    rdata_r;
  logic           err_r;
  logic [AW-1:0]  word_addr_s;
  logic           wr_s;
  logic           sel_ctrl_s;
  logic           sel_load_s;
  logic           sel_status_s;
  logic           mapped_s;
  logic [31:0]    rd_data_s;
  logic           status_clr_s;
  logic           pend_s;
  logic           pend_set_s;
  logic           unused_bits_s;
`ifdef TIMER_IRQ_COUNT_EN
  logic           sel_irqcnt_s;
  logic [31:0]    irqcnt_r;
`endif

  assign word_addr_s  = {bus.addr[AW-1:2], 2'b00};
  assign wr_s         = bus.req & bus.we;
  assign status_clr_s = wr_s & sel_status_s & bus.be[0] & bus.wdata[0];

  // Address decode and read-data selection
  always_comb begin
    sel_ctrl_s   = 1'b0;
    sel_load_s   = 1'b0;
    sel_status_s = 1'b0;
    mapped_s     = 1'b1;
    rd_data_s    = 32'h0000_0000;
`ifdef TIMER_IRQ_COUNT_EN
    sel_irqcnt_s = 1'b0;
`endif
    case (word_addr_s)
      AW'(TMR_CTRL_OFF): begin
        sel_ctrl_s = 1'b1;
        rd_data_s  = {29'h0, ctrl_r};
      end
      AW'(TMR_LOAD_OFF): begin
        sel_load_s = 1'b1;
        rd_data_s  = load_r;
      end
      AW'(TMR_VALUE_OFF): begin
        rd_data_s = timer_current_value;
      end
      AW'(TMR_STATUS_OFF): begin
        sel_status_s = 1'b1;
        rd_data_s    = {31'h0, pend_s};
      end
`ifdef TIMER_IRQ_COUNT_EN
      AW'(TMR_IRQCNT_OFF): begin
        sel_irqcnt_s = 1'b1;
        rd_data_s    = irqcnt_r;
      end
`endif
      default: begin
        mapped_s = 1'b0;
      end
    endcase
  end

  // CTRL/LOAD registers; only byte 0 of CTRL holds implemented bits
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      ctrl_r <= '0;
      load_r <= LOAD_RST;
    end else begin
      if (wr_s && sel_ctrl_s && bus.be[0]) begin
        ctrl_r <= bus.wdata[2:0];
      end
      if (wr_s && sel_load_s) begin
        load_r <= apply_be(load_r, bus.wdata, bus.be);
      end
    end
  end

  // One response per grant, presented the cycle after acceptance
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      rvalid_r <= 1'b0;
      rdata_r  <= 32'h0000_0000;
      err_r    <= 1'b0;
    end else begin
      rvalid_r <= bus.req;
      rdata_r  <= (bus.req && !bus.we && mapped_s) ? rd_data_s : 32'h0000_0000;
      err_r    <= bus.req & ~mapped_s;
    end
  end

  timer_evt_detect u_evt (
    .clk       (clk),
    .rstn      (rstn),
    .evt_in    (timer_irq_in),
    .clr       (status_clr_s),
    .flag      (pend_s),
    .set_pulse (pend_set_s)
  );

`ifdef TIMER_IRQ_COUNT_EN
  // Interrupt event counter; a software write wins over a same-cycle event
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      irqcnt_r <= 32'h0000_0000;
    end else if (wr_s && sel_irqcnt_s) begin
      irqcnt_r <= 32'h0000_0000;
    end else if (pend_set_s) begin
      irqcnt_r <= irqcnt_r + 32'd1;
    end
  end
  assign unused_bits_s = ^bus.addr[1:0];
`else
  assign unused_bits_s = ^{bus.addr[1:0], pend_set_s};
`endif

  assign bus.gnt          = bus.req;
  assign bus.rvalid       = rvalid_r;
  assign bus.rdata        = rdata_r;
  assign bus.err          = err_r;
  assign timer_enable     = ctrl_r.en;
  assign timer_mode       = ctrl_r.mode;
  assign timer_load_count = load_r;
  assign irq_o            = pend_s & ctrl_r.ie;

endmodule

// File: tb/tb_timer_ctrl_regs.sv
// Self-checking bench for timer_ctrl_regs with a transaction-level register model
// and a simple down-counter model standing in for the timer.
module tb_timer_ctrl_regs;

  localparam int AW = 8;
`ifdef TIMER_IRQ_COUNT_EN
  localparam bit CNT_EN = 1'b1;
`else
  localparam bit CNT_EN = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        rstn;
  logic        timer_enable;
  logic        timer_mode;
  logic [31:0] timer_load_count;
  logic [31:0] timer_current_value;
  logic        timer_irq_in;
  logic        irq_o;

  always #5 clk = ~clk;

  timer_ctrl_regs_if #(.AW(AW)) bus ();

  timer_ctrl_regs #(.AW(AW), .LOAD_RST(32'hFFFF_FFFF)) dut (
    .clk                 (clk),
    .rstn                (rstn),
    .bus                 (bus),
    .timer_enable        (timer_enable),
    .timer_mode          (timer_mode),
    .timer_load_count    (timer_load_count),
    .timer_current_value (timer_current_value),
    .timer_irq_in        (timer_irq_in),
    .irq_o               (irq_o)
  );

  // Behavioural timer counter, or manual drive of the counter outputs
  logic        use_cnt;
  logic        irq_man;
  logic [31:0] val_man;
  logic [31:0] cnt;
  logic        en_q;

  always @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      cnt  <= 32'h0;
      en_q <= 1'b0;
    end else begin
      en_q <= timer_enable;
      if (timer_enable && (!en_q || cnt == 32'h0))
        cnt <= timer_mode ? timer_load_count : 32'hFFFF_FFFF;
      else if (timer_enable)
        cnt <= cnt - 32'd1;
    end
  end

  assign timer_irq_in        = use_cnt ? (timer_enable && en_q && cnt == 32'h0) : irq_man;
  assign timer_current_value = use_cnt ? cnt : val_man;

  // Register model
  logic [2:0]  m_ctrl;
  logic [31:0] m_load;
  logic [31:0] m_irqcnt;
  bit          m_pend;
  bit          m_prev;

  int          n_checks = 0;
  int          n_pass   = 0;

  bit          obs_rv;
  logic [31:0] obs_rd;
  bit          obs_er;
  logic [31:0] exp_rd;
  bit          exp_er;

  task automatic model_reset();
    m_ctrl   = 3'd0;
    m_load   = 32'hFFFF_FFFF;
    m_irqcnt = 32'h0;
    m_pend   = 1'b0;
    m_prev   = 1'b0;
  endtask

  // One bus cycle: drive, predict from the model, clock, sample the response
  task automatic access(input bit req, input bit we, input logic [7:0] addr,
                        input logic [3:0] be, input logic [31:0] wdata);
    bit set_ev;
    bit clr;
    bit cnt_wr;
    int w;
    bus.req = req; bus.we = we; bus.addr = addr; bus.be = be; bus.wdata = wdata;
    #1;
    w      = int'(addr[7:2]);
    exp_er = 1'b0;
    exp_rd = 32'h0;
    if (w == 0)                exp_rd = {29'h0, m_ctrl};
    else if (w == 1)           exp_rd = m_load;
    else if (w == 2)           exp_rd = timer_current_value;
    else if (w == 3)           exp_rd = {31'h0, m_pend};
    else if (w == 4 && CNT_EN) exp_rd = m_irqcnt;
    else                       exp_er = 1'b1;
    set_ev = timer_irq_in && !m_prev;
    m_prev = timer_irq_in;
    clr    = 1'b0;
    cnt_wr = 1'b0;
    if (req && we) begin
      if (w == 0 && be[0]) m_ctrl = wdata[2:0];
      if (w == 1)
        for (int b = 0; b < 4; b++)
          if (be[b]) m_load[8*b +: 8] = wdata[8*b +: 8];
      if (w == 3) clr = be[0] && wdata[0];
      if (w == 4 && CNT_EN) cnt_wr = 1'b1;
    end
    m_pend = set_ev || (m_pend && !clr);
    if (cnt_wr)      m_irqcnt = 32'h0;
    else if (set_ev) m_irqcnt = m_irqcnt + 32'd1;
    @(posedge clk);
    #1;
    obs_rv = bus.rvalid;
    obs_rd = bus.rdata;
    obs_er = bus.err;
  endtask

  task automatic test_reset();
    logic [31:0] want [3];
    logic [7:0]  addrs [3];
    want  = '{32'h0, 32'hFFFF_FFFF, 32'h0};
    addrs = '{8'h00, 8'h04, 8'h0C};
    access(1'b1, 1'b1, 8'h04, 4'hF, 32'h1234_5678);
    access(1'b1, 1'b0, 8'h04, 4'hF, 32'h0);
    #3 rstn = 1'b0;
    #1;
    n_checks++;
    if (bus.rvalid !== 1'b0 || bus.rdata !== 32'h0 || bus.err !== 1'b0 || timer_enable !== 1'b0 ||
        timer_mode !== 1'b0 || timer_load_count !== 32'hFFFF_FFFF || irq_o !== 1'b0)
      $display("FAIL reset_outputs: rv=%b rd=%h err=%b en=%b mode=%b load=%h irq=%b want 0/0/0/0/0/ffffffff/0",
               bus.rvalid, bus.rdata, bus.err, timer_enable, timer_mode, timer_load_count, irq_o);
    else n_pass++;
    @(posedge clk); #1;
    n_checks++;
    if (bus.rvalid !== 1'b0) $display("FAIL reset_discard: rvalid=%b want 0", bus.rvalid);
    else n_pass++;
    rstn = 1'b1;
    model_reset();
    for (int i = 0; i < 3; i++) begin
      access(1'b1, 1'b0, addrs[i], 4'hF, 32'h0);
      n_checks++;
      if (obs_rv !== 1'b1 || obs_er !== 1'b0 || obs_rd !== want[i])
        $display("FAIL reset_read_%h: rv=%b err=%b rd=%h want 1/0/%h", addrs[i], obs_rv, obs_er, obs_rd, want[i]);
      else n_pass++;
    end
    access(1'b0, 1'b0, 8'h00, 4'h0, 32'h0);
    n_checks++;
    if (obs_rv !== 1'b0) $display("FAIL idle_rvalid: rv=%b want 0", obs_rv);
    else n_pass++;
  endtask

  task automatic test_counter_irq();
    bit seen;
    use_cnt = 1'b1;
    access(1'b1, 1'b1, 8'h04, 4'hF, 32'h10);
    access(1'b1, 1'b1, 8'h00, 4'hF, 32'h7);
    n_checks++;
    if (timer_enable !== 1'b1 || timer_mode !== 1'b1 || timer_load_count !== 32'h10)
      $display("FAIL ctrl_outputs: en=%b mode=%b load=%h want 1/1/00000010", timer_enable, timer_mode, timer_load_count);
    else n_pass++;
    seen = 1'b0;
    for (int i = 1; i <= 24; i++) begin
      access(1'b0, 1'b0, 8'h00, 4'h0, 32'h0);
      n_checks++;
      if (irq_o !== (m_pend && m_ctrl[2])) $display("FAIL count_irq_c%0d: irq=%b want %b", i, irq_o, m_pend && m_ctrl[2]);
      else n_pass++;
      if (i == 16) begin
        n_checks++;
        if (irq_o !== 1'b0) $display("FAIL irq_early: irq=%b want 0", irq_o);
        else n_pass++;
      end
      seen = seen | irq_o;
    end
    n_checks++;
    if (seen !== 1'b1 || irq_o !== 1'b1) $display("FAIL irq_timeout: irq=%b want 1 within 24 cycles", irq_o);
    else n_pass++;
    access(1'b1, 1'b0, 8'h0C, 4'hF, 32'h0);
    n_checks++;
    if (obs_rd !== 32'h1) $display("FAIL status_pend: rd=%h want 00000001", obs_rd);
    else n_pass++;
    access(1'b1, 1'b1, 8'h00, 4'hF, 32'h4);
    irq_man = 1'b0;
    use_cnt = 1'b0;
  endtask

  task automatic test_w1c_race();
    access(1'b1, 1'b1, 8'h0C, 4'h1, 32'h1);
    access(1'b1, 1'b0, 8'h0C, 4'hF, 32'h0);
    n_checks++;
    if (obs_rd !== 32'h0) $display("FAIL w1c_clear: rd=%h want 0", obs_rd);
    else n_pass++;
    irq_man = 1'b1;
    access(1'b1, 1'b1, 8'h0C, 4'h1, 32'h1);
    access(1'b1, 1'b0, 8'h0C, 4'hF, 32'h0);
    n_checks++;
    if (obs_rd !== 32'h1) $display("FAIL set_wins: rd=%h want 1", obs_rd);
    else n_pass++;
    access(1'b1, 1'b1, 8'h0C, 4'h1, 32'h1);
    access(1'b1, 1'b0, 8'h0C, 4'hF, 32'h0);
    n_checks++;
    if (obs_rd !== 32'h0) $display("FAIL w1c_after: rd=%h want 0", obs_rd);
    else n_pass++;
  endtask

  task automatic test_ie_mask();
    irq_man = 1'b0;
    access(1'b0, 1'b0, 8'h00, 4'h0, 32'h0);
    irq_man = 1'b1;
    access(1'b0, 1'b0, 8'h00, 4'h0, 32'h0);
    n_checks++;
    if (irq_o !== 1'b1) $display("FAIL ie_on: irq=%b want 1", irq_o);
    else n_pass++;
    access(1'b1, 1'b1, 8'h00, 4'hF, 32'h0);
    n_checks++;
    if (irq_o !== 1'b0) $display("FAIL ie_mask: irq=%b want 0", irq_o);
    else n_pass++;
    access(1'b1, 1'b0, 8'h0C, 4'hF, 32'h0);
    n_checks++;
    if (obs_rd !== 32'h1) $display("FAIL ie_keep_pend: rd=%h want 1", obs_rd);
    else n_pass++;
    access(1'b1, 1'b1, 8'h00, 4'hF, 32'h4);
    n_checks++;
    if (irq_o !== 1'b1) $display("FAIL ie_unmask: irq=%b want 1", irq_o);
    else n_pass++;
  endtask

  task automatic test_map_edges();
    access(1'b1, 1'b0, 8'h20, 4'hF, 32'h0);
    n_checks++;
    if (obs_rv !== 1'b1 || obs_er !== 1'b1 || obs_rd !== 32'h0)
      $display("FAIL unmapped_read: rv=%b err=%b rd=%h want 1/1/0", obs_rv, obs_er, obs_rd);
    else n_pass++;
    access(1'b1, 1'b1, 8'h04, 4'hF, 32'h0);
    access(1'b1, 1'b1, 8'h08, 4'hF, 32'hDEAD_BEEF);
    n_checks++;
    if (obs_er !== 1'b0) $display("FAIL value_write_err: err=%b want 0", obs_er);
    else n_pass++;
    access(1'b1, 1'b1, 8'h04, 4'b0010, 32'hAABB_CCDD);
    access(1'b1, 1'b0, 8'h04, 4'hF, 32'h0);
    n_checks++;
    if (obs_rd !== 32'h0000_CC00) $display("FAIL load_byte1: rd=%h want 0000cc00", obs_rd);
    else n_pass++;
    access(1'b1, 1'b0, 8'h10, 4'hF, 32'h0);
    n_checks++;
    if (obs_er !== !CNT_EN) $display("FAIL irqcnt_decode: err=%b want %b", obs_er, !CNT_EN);
    else n_pass++;
  endtask

`ifdef TIMER_IRQ_COUNT_EN
  task automatic test_irqcnt();
    irq_man = 1'b0;
    access(1'b1, 1'b1, 8'h10, 4'h1, 32'h0);
    for (int i = 0; i < 3; i++) begin
      irq_man = 1'b1; access(1'b0, 1'b0, 8'h0, 4'h0, 32'h0);
      irq_man = 1'b0; access(1'b0, 1'b0, 8'h0, 4'h0, 32'h0);
    end
    access(1'b1, 1'b0, 8'h10, 4'hF, 32'h0);
    n_checks++;
    if (obs_rd !== 32'd3) $display("FAIL irqcnt_three: rd=%h want 3", obs_rd);
    else n_pass++;
    dut.irqcnt_r = 32'hFFFF_FFFF;
    m_irqcnt = 32'hFFFF_FFFF;
    irq_man = 1'b1; access(1'b0, 1'b0, 8'h0, 4'h0, 32'h0);
    irq_man = 1'b0;
    access(1'b1, 1'b0, 8'h10, 4'hF, 32'h0);
    n_checks++;
    if (obs_rd !== 32'h0) $display("FAIL irqcnt_wrap: rd=%h want 0", obs_rd);
    else n_pass++;
    irq_man = 1'b1;
    access(1'b1, 1'b1, 8'h10, 4'h0, 32'h0);
    access(1'b1, 1'b0, 8'h10, 4'hF, 32'h0);
    n_checks++;
    if (obs_rd !== 32'h0) $display("FAIL irqcnt_wr_race: rd=%h want 0", obs_rd);
    else n_pass++;
    irq_man = 1'b0;
  endtask
`endif

  task automatic test_back_to_back_random();
    bit          req, we;
    int          w;
    logic [7:0]  a;
    logic [3:0]  be;
    logic [31:0] wd;
    for (int i = 0; i < 400; i++) begin
      req     = ($urandom_range(0, 9) < 8);
      we      = $urandom_range(0, 1);
      w       = $urandom_range(0, 9);
      a       = 8'(w * 4 + $urandom_range(0, 3));
      be      = 4'($urandom_range(0, 15));
      wd      = $urandom;
      irq_man = ($urandom_range(0, 3) == 0);
      val_man = $urandom;
      access(req, we, a, be, wd);
      n_checks++;
      if (obs_rv !== req || bus.gnt !== req || (req && obs_er !== exp_er) || (req && !we && obs_rd !== exp_rd))
        $display("FAIL rand_resp_%0d: a=%h we=%b rv=%b err=%b rd=%h want rv=%b err=%b rd=%h",
                 i, a, we, obs_rv, obs_er, obs_rd, req, exp_er, exp_rd);
      else n_pass++;
      n_checks++;
      if (irq_o !== (m_pend && m_ctrl[2]) || timer_enable !== m_ctrl[0] ||
          timer_mode !== m_ctrl[1] || timer_load_count !== m_load)
        $display("FAIL rand_outs_%0d: irq=%b en=%b mode=%b load=%h want %b/%b/%b/%h", i, irq_o,
                 timer_enable, timer_mode, timer_load_count, m_pend && m_ctrl[2], m_ctrl[0], m_ctrl[1], m_load);
      else n_pass++;
    end
  endtask

  initial begin
    rstn = 1'b0; use_cnt = 1'b0; irq_man = 1'b0; val_man = 32'h0;
    bus.req = 1'b0; bus.we = 1'b0; bus.addr = '0; bus.be = 4'h0; bus.wdata = 32'h0;
    model_reset();
    repeat (2) @(posedge clk);
    #1 rstn = 1'b1;
    test_reset();
    test_counter_irq();
    test_w1c_race();
    test_ie_mask();
    test_map_edges();
`ifdef TIMER_IRQ_COUNT_EN
    test_irqcnt();
`endif
    test_back_to_back_random();
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
